prco_mem_arbiter: RTL and testbench
===================================

Name: prco_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch unit (IF) and its load/store unit (LS).
- Fixed-priority arbitration favours LS, with a starvation guard that forces an IF grant after a bounded run of LS grants.
- Sequences each access through issue, latency-wait and acknowledge phases.
- Drives a stall indication back to the pipeline.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 2, cycles from the q_mem_en cycle to the cycle i_mem_rdata is valid; legal range is 1 or more.
- STARVE_MAX, 4, consecutive LS grants allowed while IF is waiting before IF is forced.

Ports:
- i_clk  in  1  core clock; all logic is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_en  in  1  arbiter enable; when low, no new grants are issued and an in-flight access still completes.
- i_if_req  in  1  fetch request, held until q_if_ack.
- i_if_addr  in  AW  fetch address.
- q_if_ack  out  1  one-cycle fetch completion pulse.
- q_if_rdata  out  DW  fetch data, valid with q_if_ack and held until the next IF ack.
- i_ls_req  in  1  load/store request, held until q_ls_ack.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_addr  in  AW  load/store address.
- i_ls_wdata  in  DW  store data.
- q_ls_ack  out  1  one-cycle load/store completion pulse.
- q_ls_rdata  out  DW  load data, valid with q_ls_ack and held until the next LS ack.
- q_mem_en  out  1  RAM access strobe, one cycle per access.
- q_mem_we  out  1  RAM write enable.
- q_mem_addr  out  AW  RAM address.
- q_mem_wdata  out  DW  RAM write data.
- i_mem_rdata  in  DW  RAM read data.
- q_stall  out  1  combinational: (i_if_req & ~q_if_ack) | (i_ls_req & ~q_ls_ack).
- q_busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset: asynchronous assertion forces:
  - state = IDLE and starve counter = 0;
  - all q_* registered outputs = 0, including both rdata registers;
  - any in-flight access is abandoned without an ack.
- States:
  - IDLE: a grant happens when i_en=1 and any req=1. The owner, address, we and wdata are latched, then go to ACCESS.
  - ACCESS: one cycle. q_mem_en=1, with q_mem_addr/q_mem_we/q_mem_wdata taken from the latch. A write goes to ACK; a read goes to WAIT.
  - WAIT: exactly MEM_LAT cycles. At the end of the last WAIT cycle, i_mem_rdata is captured into the owner's rdata register. Then go to ACK.
  - ACK: one cycle. The owner's ack = 1, then return to IDLE. Request inputs are ignored during ACK.
- Latency, counted from req high in IDLE at cycle T:
  - write ack in cycle T+2;
  - read ack in cycle T+2+MEM_LAT.
  - Back-to-back accesses: the next grant is sampled in the IDLE cycle after ACK.
- Arbitration, applied in IDLE only:
  - Only one req high: that port wins.
  - Both high: LS wins unless starve counter == STARVE_MAX, in which case IF wins.
- Starve counter:
  - increments on each LS grant made while i_if_req=1;
  - clears on any IF grant;
  - clears on any LS grant made while i_if_req=0;
  - saturates at STARVE_MAX.
- IF accesses are always reads. q_mem_we=0 for an IF access regardless of i_ls_we.
- q_mem_* outside ACCESS: q_mem_en=0 and q_mem_we=0; address and wdata hold their last value.
- Boundary conditions:
  - A req dropped before its ack is a protocol violation. The latched access still completes and is acked.
  - i_en falling mid-access has no effect on that access.
  - A req rising during ACCESS, WAIT or ACK is serviced at the next IDLE.
  - MEM_LAT=1 gives a single WAIT cycle.
  - Address and data are passed through unmodified; there is no width arithmetic.

Test Plan:
- Reset is low for 2 cycles, then i_reset_n=1 and i_en=1 with no requests. Required: all outputs 0, q_busy=0. Asserting i_reset_n=0 mid-WAIT drops q_busy immediately, and no ack follows.
- LS store (we=1, addr=0x0010, wdata=0xBEEF) in cycle 0. Required: q_mem_en=1 with those values in cycle 1, q_ls_ack=1 in cycle 2, q_stall=1 in cycles 0–1.
- IF read of addr 0x0004 with the RAM model returning 0x1234 at MEM_LAT=2. Required: q_mem_en in cycle 1, q_if_ack=1 with q_if_rdata=0x1234 in cycle 4, and q_if_rdata still 0x1234 afterwards.
- IF and LS requesting simultaneously and continuously, STARVE_MAX=4. Required grant sequence: LS, LS, LS, LS, IF, LS… The counter clears after the IF grant.
- i_en=0 with both reqs high for 5 cycles. Required: no q_mem_en and q_stall=1. Raising i_en then produces an LS grant on the next cycle.
- IF drops its req in ACCESS. Required: the IF access still completes and q_if_ack pulses in cycle T+2+MEM_LAT.

Source files
------------

// File: rtl/prco_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Load/store has fixed priority; a starvation counter forces a fetch grant after STARVE_MAX LS wins.
module prco_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          q_if_ack,
  output logic [DW-1:0] q_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          q_ls_ack,
  output logic [DW-1:0] q_ls_rdata,
  output logic          q_mem_en,
  output logic          q_mem_we,
  output logic [AW-1:0] q_mem_addr,
  output logic [DW-1:0] q_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          q_stall,
  output logic          q_busy
);

  localparam int WCW = $clog2(MEM_LAT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t         state, state_nxt;
  logic           grant, grant_ls, last_wait;
  logic           own_ls;
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] starve_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_ls  = 1'b0;
    last_wait = (wait_cnt == '0);
    case (state)
      IDLE: begin
        if (i_en && (i_if_req || i_ls_req)) begin
          grant     = 1'b1;
          grant_ls  = i_ls_req && !(i_if_req && starve_cnt == SCW'(STARVE_MAX));
          state_nxt = ACCESS;
        end
      end
      // q_mem_we is high only during ACCESS, so it tells us whether this access is a store
      ACCESS:  state_nxt = q_mem_we ? ACK : WAIT;
      WAIT:    if (last_wait) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      own_ls      <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      q_mem_en    <= 1'b0;
      q_mem_we    <= 1'b0;
      q_mem_addr  <= '0;
      q_mem_wdata <= '0;
      q_if_ack    <= 1'b0;
      q_ls_ack    <= 1'b0;
      q_if_rdata  <= '0;
      q_ls_rdata  <= '0;
    end else begin
      q_mem_en <= 1'b0;
      q_mem_we <= 1'b0;
      q_if_ack <= 1'b0;
      q_ls_ack <= 1'b0;
      if (grant) begin
        own_ls     <= grant_ls;
        q_mem_en   <= 1'b1;
        q_mem_we   <= grant_ls & i_ls_we;
        q_mem_addr <= grant_ls ? i_ls_addr : i_if_addr;
        if (grant_ls) q_mem_wdata <= i_ls_wdata;
        if (!grant_ls || !i_if_req)
          starve_cnt <= '0;
        else if (starve_cnt != SCW'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == ACCESS) begin
        wait_cnt <= WCW'(MEM_LAT - 1);
        if (q_mem_we) begin
          q_ls_ack <= own_ls;
          q_if_ack <= ~own_ls;
        end
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
        if (last_wait) begin
          if (own_ls) begin
            q_ls_ack   <= 1'b1;
            q_ls_rdata <= i_mem_rdata;
          end else begin
            q_if_ack   <= 1'b1;
            q_if_rdata <= i_mem_rdata;
          end
        end
      end
    end
  end

  assign q_stall = (i_if_req & ~q_if_ack) | (i_ls_req & ~q_ls_ack);
  assign q_busy  = (state != IDLE);

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// Directed and randomized bench for prco_mem_arbiter, checked cycle by cycle
// against a transaction-level model that schedules strobe and ack cycles arithmetically.
module tb_prco_mem_arbiter;

  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic          i_clk      = 1'b0;
  logic          i_reset_n  = 1'b0;
  logic          i_en       = 1'b0;
  logic          i_if_req   = 1'b0;
  logic          i_ls_req   = 1'b0;
  logic          i_ls_we    = 1'b0;
  logic [AW-1:0] i_if_addr  = '0;
  logic [AW-1:0] i_ls_addr  = '0;
  logic [DW-1:0] i_ls_wdata = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          q_if_ack, q_ls_ack, q_mem_en, q_mem_we, q_stall, q_busy;
  logic [DW-1:0] q_if_rdata, q_ls_rdata, q_mem_wdata;
  logic [AW-1:0] q_mem_addr;

  always #5 i_clk = ~i_clk;

  prco_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .q_if_ack(q_if_ack), .q_if_rdata(q_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .q_ls_ack(q_ls_ack), .q_ls_rdata(q_ls_rdata),
    .q_mem_en(q_mem_en), .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr),
    .q_mem_wdata(q_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .q_stall(q_stall), .q_busy(q_busy)
  );

  function automatic logic [DW-1:0] seed(input int a);
    return (a == 4) ? 16'h1234 : DW'(32'hA500 + a * 32'h0111);
  endfunction

  // RAM: 16 words indexed by the low address bits; non-strobe cycles feed garbage into the read pipe
  logic [DW-1:0] ram   [16];
  logic [DW-1:0] rpipe [MEM_LAT];
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= seed(i);
    end else if (q_mem_en && q_mem_we) begin
      ram[q_mem_addr[3:0]] <= q_mem_wdata;
    end
    rpipe[0] <= q_mem_en ? ram[q_mem_addr[3:0]] : DW'($urandom);
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign i_mem_rdata = rpipe[MEM_LAT-1];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            if_pend, ls_pend, if_drop, ls_w;
  logic [AW-1:0] if_a, ls_a;
  logic [DW-1:0] ls_d;
  int            p_if, p_ls, en_mode;
  int            en_at, ack_at, busy_until, starve;
  bit            ack_ls, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, pend_rd, exp_if_rd, exp_ls_rd;
  logic [DW-1:0] ref_mem [16];
  logic [9:0]    acks;
  int            n_acks;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    en_at = -1; ack_at = -1; busy_until = 0; starve = 0;
    ack_ls = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wdata = '0; pend_rd = '0; exp_if_rd = '0; exp_ls_rd = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
  endtask

  task automatic applyStimulus();
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1'b1; if_a = AW'($urandom);
    end
    if (!ls_pend && $urandom_range(99) < p_ls) begin
      ls_pend = 1'b1; ls_a = AW'($urandom); ls_w = 1'($urandom_range(1)); ls_d = DW'($urandom);
    end
    i_en       = (en_mode == 2) ? ($urandom_range(3) != 0) : (en_mode == 1);
    i_if_req   = if_pend && !if_drop;
    i_if_addr  = if_a;
    i_ls_req   = ls_pend;
    i_ls_addr  = ls_a;
    i_ls_we    = ls_w;
    i_ls_wdata = ls_d;
  endtask

  // Compare this cycle's outputs, then decide a grant: a grant at cycle g strobes at g+1,
  // acks at g+2 (store) or g+2+MEM_LAT (read), and the next grant is possible after the ack.
  task automatic modelCheck();
    bit e_if_ack, e_ls_ack, ls_wins;
    e_if_ack = (cyc == ack_at) && !ack_ls;
    e_ls_ack = (cyc == ack_at) && ack_ls;
    if (e_if_ack) exp_if_rd = pend_rd;
    if (e_ls_ack && !exp_we) exp_ls_rd = pend_rd;
    checkOutput("mem_en", q_mem_en, cyc == en_at);
    checkOutput("mem_we", q_mem_we, (cyc == en_at) && exp_we);
    checkOutput("mem_addr", q_mem_addr, exp_addr);
    if (cyc == en_at && exp_we) checkOutput("mem_wdata", q_mem_wdata, exp_wdata);
    checkOutput("if_ack", q_if_ack, e_if_ack);
    checkOutput("ls_ack", q_ls_ack, e_ls_ack);
    checkOutput("if_rdata", q_if_rdata, exp_if_rd);
    checkOutput("ls_rdata", q_ls_rdata, exp_ls_rd);
    checkOutput("busy", q_busy, (cyc >= en_at) && (cyc < busy_until));
    checkOutput("stall", q_stall, (i_if_req && !e_if_ack) || (i_ls_req && !e_ls_ack));
    if (e_if_ack) if_pend = 1'b0;
    if (e_ls_ack) ls_pend = 1'b0;
    if (i_reset_n && i_en && cyc >= busy_until && (i_if_req || i_ls_req)) begin
      ls_wins = i_ls_req && !(i_if_req && starve == STARVE_MAX);
      if (ls_wins) begin
        starve   = i_if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
        exp_addr = i_ls_addr;
        exp_we   = i_ls_we;
        if (i_ls_we) begin
          exp_wdata = i_ls_wdata;
          ref_mem[i_ls_addr[3:0]] = i_ls_wdata;
        end
      end else begin
        starve   = 0;
        exp_addr = i_if_addr;
        exp_we   = 1'b0;
      end
      if (!exp_we) pend_rd = ref_mem[exp_addr[3:0]];
      ack_ls     = ls_wins;
      en_at      = cyc + 1;
      ack_at     = cyc + (exp_we ? 2 : 2 + MEM_LAT);
      busy_until = ack_at + 1;
    end
  endtask

  task automatic stepCycle();
    @(posedge i_clk);
    #1;
    cyc++;
    applyStimulus();
    @(negedge i_clk);
    modelCheck();
  endtask

  task automatic drain();
    p_if = 0; p_ls = 0; en_mode = 1;
    for (int i = 0; i < 60 && (if_pend || ls_pend || cyc < busy_until); i++) stepCycle();
    checkOutput("drain_idle", {if_pend, ls_pend, q_busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    if_pend = 0; ls_pend = 0; if_drop = 0; ls_w = 0;
    if_a = '0; ls_a = '0; ls_d = '0;
    p_if = 0; p_ls = 0; en_mode = 1;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_mem_en", q_mem_en, 0);
    checkOutput("rst_acks", {q_if_ack, q_ls_ack}, 0);
    checkOutput("rst_rdata", {q_if_rdata, q_ls_rdata}, 0);
    checkOutput("rst_busy", q_busy, 0);
    checkOutput("rst_stall", q_stall, 0);
    i_reset_n = 1'b1;
    repeat (3) stepCycle();
    checkOutput("idle_busy", q_busy, 0);

    // Store 0xBEEF to 0x0010
    ls_pend = 1; ls_a = 16'h0010; ls_w = 1; ls_d = 16'hBEEF;
    stepCycle();
    checkOutput("st_stall_c0", q_stall, 1);
    stepCycle();
    checkOutput("st_en_c1", {q_mem_en, q_mem_we}, 2'b11);
    checkOutput("st_addr_c1", q_mem_addr, 16'h0010);
    checkOutput("st_wdata_c1", q_mem_wdata, 16'hBEEF);
    checkOutput("st_stall_c1", q_stall, 1);
    stepCycle();
    checkOutput("st_ack_c2", q_ls_ack, 1);
    stepCycle();

    // Fetch from 0x0004, RAM holds 0x1234
    if_pend = 1; if_a = 16'h0004;
    stepCycle();
    stepCycle();
    checkOutput("rd_en_c1", {q_mem_en, q_mem_we}, 2'b10);
    checkOutput("rd_addr_c1", q_mem_addr, 16'h0004);
    stepCycle();
    stepCycle();
    checkOutput("rd_noack_c3", q_if_ack, 0);
    stepCycle();
    checkOutput("rd_ack_c4", q_if_ack, 1);
    checkOutput("rd_data_c4", q_if_rdata, 16'h1234);
    stepCycle();
    checkOutput("rd_hold_c5", q_if_rdata, 16'h1234);

    // Both ports requesting continuously: IF is forced after four LS grants
    p_if = 100; p_ls = 100; n_acks = 0; acks = '0;
    for (int i = 0; i < 200 && n_acks < 10; i++) begin
      stepCycle();
      if (q_if_ack || q_ls_ack) begin
        acks[n_acks] = q_if_ack;
        n_acks++;
      end
    end
    checkOutput("starve_ack_count", n_acks, 10);
    checkOutput("starve_pattern", acks, 10'b10_0001_0000);
    drain();

    // Reset in the middle of WAIT abandons the fetch
    if_pend = 1; if_a = 16'h0008;
    repeat (3) stepCycle();
    i_reset_n = 1'b0;
    #1;
    checkOutput("rstwait_busy", q_busy, 0);
    checkOutput("rstwait_ack", {q_if_ack, q_ls_ack}, 0);
    modelReset();
    if_pend = 0; ls_pend = 0;
    repeat (2) stepCycle();
    i_reset_n = 1'b1;
    repeat (6) begin
      stepCycle();
      checkOutput("rstwait_no_ack", {q_if_ack, q_ls_ack}, 0);
    end

    // Enable low with both requests pending
    en_mode = 0;
    ls_pend = 1; ls_a = 16'h0123; ls_w = 0;
    if_pend = 1; if_a = 16'h0456;
    repeat (5) begin
      stepCycle();
      checkOutput("en0_mem_en", q_mem_en, 0);
      checkOutput("en0_stall", q_stall, 1);
    end
    en_mode = 1;
    stepCycle();
    stepCycle();
    checkOutput("en1_ls_en", q_mem_en, 1);
    checkOutput("en1_ls_addr", q_mem_addr, 16'h0123);
    drain();

    // Fetch request dropped during ACCESS still completes
    if_pend = 1; if_a = 16'h0003;
    stepCycle();
    if_drop = 1;
    repeat (3) stepCycle();
    stepCycle();
    checkOutput("drop_if_ack", q_if_ack, 1);
    checkOutput("drop_if_rdata", q_if_rdata, seed(3));
    if_drop = 0;
    stepCycle();

    // Random traffic with a flickering enable
    p_if = 35; p_ls = 45; en_mode = 2;
    repeat (400) stepCycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
